// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: hunts for SYNC, checks LEN and the XOR checksum,
// then replays the validated payload over a ready/valid port.
module uart_frame_parser #(
   parameter int MAX_LEN      = 16,
   parameter int TIMEOUT_CLKS = 52080
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] drop_cnt
);

   localparam int IDX_W  = $clog2(MAX_LEN + 1);
   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMR_W  = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [7:0]       SYNC     = 8'hA5;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAY, GET_CHK, DRAIN} state_t;

   state_t           state;
   logic [7:0]       buf_mem [MAX_LEN];
   logic [IDX_W-1:0] len;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] rd_next;
   logic [7:0]       chk;
   logic [TMR_W-1:0] idle_cnt;
   logic             in_frame;
   logic             timed_out;
   logic             pay_last;
   logic             rd_last;
   logic             len_bad;

   assign in_frame  = (state == GET_LEN) || (state == GET_PAY) || (state == GET_CHK);
   // A byte on the terminal cycle wins over the timeout.
   assign timed_out = in_frame && !rx_done && (idle_cnt == TMR_LAST);
   assign pay_last  = (wr_idx == len - IDX_ONE);
   assign rd_last   = (rd_idx == len - IDX_ONE);
   assign rd_next   = rd_idx + IDX_ONE;
   assign len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));

   // Payload storage is not reset; it is always written before it is read.
   always_ff @(posedge clk) begin
      if (state == GET_PAY && rx_done)
         buf_mem[wr_idx[ADDR_W-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         len       <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         chk       <= 8'h00;
         idle_cnt  <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         drop_cnt  <= 8'h00;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         idle_cnt  <= (in_frame && !rx_done && !timed_out) ? idle_cnt + TMR_W'(1) : '0;

         if (timed_out) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
            state     <= HUNT;
         end else begin
            case (state)
               HUNT: begin
                  if (rx_done && rx_data == SYNC)
                     state <= GET_LEN;
               end
               GET_LEN: begin
                  if (rx_done) begin
                     if (len_bad) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b01;
                        state     <= HUNT;
                     end else begin
                        len    <= rx_data[IDX_W-1:0];
                        chk    <= rx_data;
                        wr_idx <= '0;
                        state  <= GET_PAY;
                     end
                  end
               end
               GET_PAY: begin
                  if (rx_done) begin
                     chk    <= chk ^ rx_data;
                     wr_idx <= wr_idx + IDX_ONE;
                     if (pay_last)
                        state <= GET_CHK;
                  end
               end
               GET_CHK: begin
                  if (rx_done) begin
                     if (rx_data == chk) begin
                        frame_ok  <= 1'b1;
                        rd_idx    <= '0;
                        out_data  <= buf_mem[0];
                        out_valid <= 1'b1;
                        out_last  <= (len == IDX_ONE);
                        state     <= DRAIN;
                     end else begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b10;
                        state     <= HUNT;
                     end
                  end
               end
               DRAIN: begin
                  if (rx_done && drop_cnt != 8'hFF)
                     drop_cnt <= drop_cnt + 8'd1;
                  if (out_ready) begin
                     if (rd_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= HUNT;
                     end else begin
                        rd_idx   <= rd_next;
                        out_data <= buf_mem[rd_next[ADDR_W-1:0]];
                        out_last <= (rd_next == len - IDX_ONE);
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: a small frame model pushes expected
// events and payload bytes into queues that a negedge monitor pops and compares.
module tb_uart_frame_parser;

   localparam int MAX_LEN      = 16;
   localparam int TIMEOUT_CLKS = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   logic [2:0] ev_q[$];
   logic [8:0] byte_q[$];
   logic [7:0] pay [16];
   logic [2:0] obs_ev;
   logic [2:0] exp_ev;
   logic [8:0] exp_b;
   logic       seen;
   logic [7:0] c;

   uart_frame_parser #(
      .MAX_LEN(MAX_LEN),
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_done(rx_done),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .frame_ok(frame_ok),
      .frame_err(frame_err),
      .err_code(err_code),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   // Frame model: decides the outcome from LEN and the XOR of LEN and payload.
   task automatic apply_stimulus(input logic [7:0] len, input logic [7:0] chk_byte);
      logic [7:0] x;
      send_byte(8'hA5);
      if (len == 8'd0 || int'(len) > MAX_LEN) begin
         ev_q.push_back(3'b101);
         send_byte(len);
         return;
      end
      send_byte(len);
      x = len;
      for (int i = 0; i < int'(len); i++) begin
         send_byte(pay[i]);
         x = x ^ pay[i];
      end
      if (x == chk_byte) begin
         ev_q.push_back(3'b000);
         for (int i = 0; i < int'(len); i++)
            byte_q.push_back({(i == int'(len) - 1), pay[i]});
      end else begin
         ev_q.push_back(3'b110);
      end
      send_byte(chk_byte);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_ok || frame_err) begin
            check_output("ok_err_excl", 32'(frame_ok && frame_err), 0);
            obs_ev = frame_err ? {1'b1, err_code} : 3'b000;
            if (ev_q.size() == 0) begin
               check_output("unexpected_event", 32'({frame_ok, frame_err, err_code}), 0);
            end else begin
               exp_ev = ev_q.pop_front();
               check_output("event", 32'(obs_ev), 32'(exp_ev));
            end
         end
         if (out_valid) begin
            if (byte_q.size() == 0) begin
               check_output("unexpected_valid", 32'({out_valid, out_last, out_data}), 0);
            end else if (out_ready) begin
               exp_b = byte_q.pop_front();
               check_output("handshake", 32'({out_last, out_data}), 32'(exp_b));
            end else begin
               check_output("stall_data", 32'({out_last, out_data}), 32'(byte_q[0]));
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      rx_data   = 8'h00;
      rx_done   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_outs",
         32'({out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt, out_data}), 0);
      rst_n = 1'b1;
      idle(2);

      $display("[TB] good frame");
      pay = '{0: 8'h11, 1: 8'h22, 2: 8'h33, default: 8'h00};
      apply_stimulus(8'd3, 8'h03);
      @(negedge clk);
      check_output("ok_timing", 32'(frame_ok), 1);
      check_output("ok_valid_same", 32'({out_valid, out_data}), 32'h111);
      idle(MAX_LEN + 2);

      $display("[TB] bad checksum then good frame");
      pay = '{0: 8'h10, 1: 8'h20, default: 8'h00};
      apply_stimulus(8'd2, 8'h31);
      idle(3);
      pay = '{0: 8'h5A, 1: 8'hC3, default: 8'h00};
      apply_stimulus(8'd2, 8'h9B);
      idle(MAX_LEN + 2);

      $display("[TB] bad LEN");
      apply_stimulus(8'd0, 8'h00);
      idle(2);
      apply_stimulus(8'h11, 8'h00);
      idle(2);

      $display("[TB] maximum length frame");
      c = 8'd16;
      for (int i = 0; i < 16; i++) begin
         pay[i] = 8'(i * 7 + 1);
         c = c ^ pay[i];
      end
      apply_stimulus(8'd16, c);
      idle(MAX_LEN + 2);

      $display("[TB] backpressure and drops");
      out_ready = 1'b0;
      pay = '{0: 8'hAA, 1: 8'h55, default: 8'h00};
      apply_stimulus(8'd2, 8'hFD);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'hA5);
      idle(2);
      check_output("drop_cnt3", 32'(drop_cnt), 3);
      check_output("stall_hold", 32'(out_data), 32'hAA);
      out_ready = 1'b1;
      idle(MAX_LEN + 2);

      $display("[TB] timeout");
      ev_q.push_back(3'b111);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h01);
      seen = 1'b0;
      repeat (TIMEOUT_CLKS) begin
         @(negedge clk);
         if (frame_err) seen = 1'b1;
      end
      @(negedge clk);
      check_output("timeout_early", 32'(seen), 0);
      check_output("timeout_fire", 32'({frame_err, err_code}), 32'h7);
      idle(2);

      $display("[TB] byte on terminal cycle");
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h01);
      repeat (TIMEOUT_CLKS - 1) @(posedge clk);
      #1;
      send_byte(8'h02);
      ev_q.push_back(3'b000);
      byte_q.push_back({1'b0, 8'h01});
      byte_q.push_back({1'b1, 8'h02});
      repeat (TIMEOUT_CLKS - 1) @(posedge clk);
      #1;
      send_byte(8'h01);
      idle(MAX_LEN + 2);
      check_output("err_code_held", 32'(err_code), 3);

      $display("[TB] reset mid-payload");
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h44);
      rst_n = 1'b0;
      #1;
      check_output("rst_mid_pay",
         32'({out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt, out_data}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      $display("[TB] drop saturation and reset mid-drain");
      out_ready = 1'b0;
      pay = '{0: 8'h7E, default: 8'h00};
      apply_stimulus(8'd1, 8'h7F);
      for (int i = 0; i < 257; i++)
         send_byte(i[7:0]);
      check_output("drop_sat", 32'(drop_cnt), 255);
      rst_n = 1'b0;
      #1;
      check_output("rst_mid_drain",
         32'({out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt, out_data}), 0);
      byte_q.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idle(1);
      apply_stimulus(8'd1, 8'h7F);
      idle(4);

      check_output("events_left", 32'(ev_q.size()), 0);
      check_output("bytes_left", 32'(byte_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
